// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage: zero/sign/full-field widening with an
// immediate-prefix latch, behind a one-entry valid/ready output register.
module imm_extend_unit #(
    parameter int DATA_W  = 16,
    parameter int IN_W    = 8,
    parameter int SHORT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   imm_in,
    input  logic              ext_op,
    input  logic              imm_place,
    input  logic              is_prefix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_prefixed,
    output logic              prefix_pending
);

    typedef enum logic {IDLE, PREFIX} state_t;

    state_t              stateQ, stateD;
    logic [IN_W-1:0]     prefixReg;
    logic                outValid;
    logic [DATA_W-1:0]   outImm;
    logic                outPrefixed;
    logic                accept;
    logic [DATA_W-1:0]   result;
    logic [SHORT_W-1:0]  shortField;

    assign in_ready       = ~outValid | out_ready;
    // A request seen during flush is dropped even if in_ready reads 1.
    assign accept         = in_valid & in_ready & ~flush;
    assign shortField     = imm_in[SHORT_W-1:0];
    assign out_valid      = outValid;
    assign out_imm        = outImm;
    assign out_prefixed   = outPrefixed;
    assign prefix_pending = (stateQ == PREFIX);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        stateD = stateQ;
        if (flush)
            stateD = IDLE;
        else if (accept)
            stateD = is_prefix ? PREFIX : IDLE;
    end

    always_comb begin
        result = '0;
        if (stateQ == PREFIX) begin
            if (imm_place)
                result = DATA_W'({prefixReg, imm_in});
            else
                result = DATA_W'({prefixReg, shortField});
        end else if (imm_place) begin
            result = DATA_W'(imm_in);
        end else if (ext_op) begin
            result = {{(DATA_W-SHORT_W){shortField[SHORT_W-1]}}, shortField};
        end else begin
            result = DATA_W'(shortField);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stateQ <= IDLE;
        else
            stateQ <= stateD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefixReg   <= '0;
            outValid    <= 1'b0;
            outImm      <= '0;
            outPrefixed <= 1'b0;
        end else if (flush) begin
            prefixReg   <= '0;
            outValid    <= 1'b0;
            outPrefixed <= 1'b0;
        end else begin
            if (accept && !is_prefix) begin
                outImm      <= result;
                outValid    <= 1'b1;
                outPrefixed <= (stateQ == PREFIX);
            end else if (out_ready) begin
                outValid    <= 1'b0;
            end
            if (accept && is_prefix)
                prefixReg <= imm_in;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed test-plan scenarios plus
// randomized traffic against a behavioural reference model.
module tb_imm_extend_unit;

    localparam int DATA_W  = 16;
    localparam int IN_W    = 8;
    localparam int SHORT_W = 5;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   imm_in;
    logic              ext_op;
    logic              imm_place;
    logic              is_prefix;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_prefixed;
    logic              prefix_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                mValid;
    logic [DATA_W-1:0] mImm;
    bit                mPref;
    bit                mPending;
    int                mPrefix;

    imm_extend_unit #(.DATA_W(DATA_W), .IN_W(IN_W), .SHORT_W(SHORT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .imm_in(imm_in),
        .ext_op(ext_op), .imm_place(imm_place), .is_prefix(is_prefix),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_prefixed(out_prefixed), .prefix_pending(prefix_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected immediate from plain arithmetic on the field values.
    function automatic logic [DATA_W-1:0] refImm(input int imm, input bit ext, input bit place,
                                                 input bit hasPre, input int pre);
        int     field;
        longint val;
        field = place ? imm : imm % (1 << SHORT_W);
        if (hasPre)
            val = longint'(pre) * (place ? (1 << IN_W) : (1 << SHORT_W)) + field;
        else if (!place && ext && field >= (1 << (SHORT_W - 1)))
            val = field - (1 << SHORT_W);
        else
            val = field;
        return DATA_W'(val);
    endfunction

    task automatic setIn(input bit v, input int imm, input bit ext, input bit place,
                         input bit pre, input bit rdy, input bit fl);
        in_valid  = v;
        imm_in    = IN_W'(imm);
        ext_op    = ext;
        imm_place = place;
        is_prefix = pre;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance the model by the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit acc;
        acc = in_valid && (!mValid || out_ready) && !flush;
        if (flush) begin
            mValid = 0; mPref = 0; mPending = 0; mPrefix = 0;
        end else begin
            if (acc && !is_prefix) begin
                mImm     = refImm(int'(imm_in), ext_op, imm_place, mPending, mPrefix);
                mPref    = mPending;
                mValid   = 1;
                mPending = 0;
            end else if (out_ready) begin
                mValid = 0;
            end
            if (acc && is_prefix) begin
                mPending = 1;
                mPrefix  = int'(imm_in);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mValid = 0; mImm = '0; mPref = 0; mPending = 0; mPrefix = 0;
    endtask

    task automatic test_reset();
        setIn(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        modelReset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_prefixed !== 1'b0 || prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b imm=%h pref=%b pend=%b want all zero",
                     out_valid, out_imm, out_prefixed, prefix_pending);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_modes();
        int          imms  [4] = '{8'h80, 8'h1C, 8'h1C, 8'hFF};
        bit          exts  [4] = '{0, 1, 0, 0};
        bit          places[4] = '{1, 0, 0, 0};
        logic [15:0] exps  [4] = '{16'h0080, 16'hFFFC, 16'h001C, 16'h001F};
        for (int i = 0; i < 4; i++) begin
            setIn(1, imms[i], exts[i], places[i], 0, 1, 0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_imm !== exps[i] || out_prefixed !== 1'b0) begin
                errors++;
                $display("FAIL idle_mode[%0d] got valid=%b imm=%h pref=%b want 1 %h 0",
                         i, out_valid, out_imm, out_prefixed, exps[i]);
            end
        end
    endtask

    task automatic test_prefix();
        setIn(1, 8'hAB, 0, 0, 1, 1, 0);
        tick();
        checks++;
        if (prefix_pending !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL prefix_latch got pend=%b valid=%b want 1 0", prefix_pending, out_valid);
        end
        setIn(1, 8'hCD, 0, 1, 0, 1, 0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'hABCD || out_prefixed !== 1'b1 || prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL prefix_full got valid=%b imm=%h pref=%b pend=%b want 1 abcd 1 0",
                     out_valid, out_imm, out_prefixed, prefix_pending);
        end
        setIn(1, 8'h03, 0, 0, 1, 1, 0);
        tick();
        setIn(1, 8'h1F, 1, 0, 0, 1, 0);
        tick();
        checks++;
        if (out_imm !== 16'h007F || out_prefixed !== 1'b1) begin
            errors++;
            $display("FAIL prefix_short got imm=%h pref=%b want 007f 1", out_imm, out_prefixed);
        end
    endtask

    task automatic test_back_to_back();
        setIn(1, 8'h11, 0, 1, 1, 1, 0);
        tick();
        setIn(1, 8'h22, 0, 1, 1, 1, 0);
        tick();
        checks++;
        if (prefix_pending !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending got pend=%b valid=%b want 1 0", prefix_pending, out_valid);
        end
        setIn(1, 8'h33, 0, 1, 0, 1, 0);
        tick();
        checks++;
        if (out_imm !== 16'h2233 || out_prefixed !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result got imm=%h pref=%b want 2233 1", out_imm, out_prefixed);
        end
    endtask

    task automatic test_backpressure();
        setIn(1, 8'h80, 0, 1, 0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            setIn(1, $urandom_range(0, 255), 0, 1, 0, 0, 0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_imm !== 16'h0080) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b imm=%h want 1 0080", i, out_valid, out_imm);
            end
        end
        setIn(1, 8'h01, 0, 1, 0, 1, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'h0001) begin
            errors++;
            $display("FAIL release_result got valid=%b imm=%h want 1 0001", out_valid, out_imm);
        end
    endtask

    task automatic test_flush();
        // Flush while stalled with a request present
        setIn(1, 8'h77, 0, 1, 0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got valid=%b pend=%b want 0 0", out_valid, prefix_pending);
        end
        // Flush with a prefix pending and a request present
        setIn(1, 8'h55, 0, 1, 1, 1, 0);
        tick();
        setIn(1, 8'h66, 0, 1, 0, 1, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL flush_prefix got valid=%b pend=%b want 0 0", out_valid, prefix_pending);
        end
        setIn(1, 8'h10, 0, 1, 0, 1, 0);
        tick();
        checks++;
        if (out_imm !== 16'h0010 || out_prefixed !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_after got imm=%h pref=%b valid=%b want 0010 0 1",
                     out_imm, out_prefixed, out_valid);
        end
    endtask

    task automatic asyncResetCheck(input string tag);
        #1;
        reset = 1'b1;
        modelReset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_prefixed !== 1'b0 ||
            prefix_pending !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got valid=%b imm=%h pref=%b pend=%b rdy=%b want 0 0 0 0 1",
                     tag, out_valid, out_imm, out_prefixed, prefix_pending, in_ready);
        end
        #1;
        reset = 1'b0;
        setIn(0, 0, 0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_async_reset();
        setIn(1, 8'hC3, 0, 1, 0, 1, 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        tick();
        asyncResetCheck("async_reset_stall");
        setIn(1, 8'h5A, 0, 1, 1, 1, 0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        asyncResetCheck("async_reset_prefix");
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            setIn($urandom_range(0, 99) < 80, $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
            #1;
            checks++;
            if (in_ready !== (!mValid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, (!mValid || out_ready));
            end
            tick();
            checks++;
            if (out_valid !== mValid || prefix_pending !== mPending) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got valid=%b pend=%b want %b %b",
                         i, out_valid, prefix_pending, mValid, mPending);
            end
            if (mValid) begin
                checks++;
                if (out_imm !== mImm || out_prefixed !== mPref) begin
                    errors++;
                    $display("FAIL rand_data[%0d] got imm=%h pref=%b want %h %b",
                             i, out_imm, out_prefixed, mImm, mPref);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_modes();
        test_prefix();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Registered, parametrised immediate-extension stage for the decode/execute boundary of the pipeline. It widens immediates from an IN_W-bit field to DATA_W bits with zero, sign, or full-field placement. It also supports an immediate-prefix instruction, which latches upper bits that are then concatenated onto the next immediate. Results flow through a one-entry output register with valid/ready handshaking, so downstream stalls are absorbed without losing data.

## Interface
- DATA_W, 16: output immediate width; must be ≥ 2*IN_W.
- IN_W, 8: raw immediate field width.
- SHORT_W, 5: short-field width used when imm_place=0; 1 ≤ SHORT_W < IN_W.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid=1.
- imm_in  input  IN_W  raw immediate field.
- ext_op  input  1  sign-extend (1) or zero-extend (0); applies in short mode without prefix only.
- imm_place  input  1  full-field mode (1) or short-field mode (0).
- is_prefix  input  1  request is an immediate prefix; it produces no output.
- out_valid  output  1  out_imm holds a result.
- out_ready  input  1  consumer takes the result.
- out_imm  output  DATA_W  extended immediate.
- out_prefixed  output  1  result was combined with a prefix.
- prefix_pending  output  1  a prefix is held (state PREFIX).

## Operation
- Accept condition: in_valid & in_ready, where in_ready = ~out_valid | out_ready (combinational).
- State machine, two states:
  - IDLE → PREFIX on an accepted prefix.
  - PREFIX → IDLE on an accepted non-prefix request.
  - PREFIX → PREFIX on another accepted prefix: prefix_reg is overwritten, last prefix wins.
  - Any state → IDLE on flush.
- prefix_reg (IN_W bits) is loaded with imm_in on an accepted prefix.
- Results in IDLE, non-prefix request:
  - imm_place=1: out_imm = zero-extended imm_in.
  - imm_place=0, ext_op=1: out_imm = imm_in[SHORT_W-1:0] sign-extended from bit SHORT_W-1.
  - imm_place=0, ext_op=0: out_imm = imm_in[SHORT_W-1:0] zero-extended.
  - imm_in bits above SHORT_W are ignored in short mode.
- Results in PREFIX, non-prefix request:
  - imm_place=1: out_imm = {zeros, prefix_reg, imm_in}.
  - imm_place=0: out_imm = {zeros, prefix_reg, imm_in[SHORT_W-1:0]}.
  - Upper bits are zero-filled to DATA_W; ext_op is ignored; out_prefixed=1.
- Output register update:
  - Loaded on every accepted non-prefix request; out_valid set to 1.
  - Otherwise out_valid is cleared when out_ready=1; out_imm holds its value.
  - Accepted prefixes never touch the output register.
- Flush has the highest priority:
  - Clears out_valid, out_prefixed, prefix_reg and state.
  - Any request presented in the flush cycle is dropped, even though in_ready may read 1.
- prefix_pending is exactly (state==PREFIX).

## Timing
- Reset (asynchronous): state=IDLE, prefix_reg=0, out_valid=0, out_imm=0, out_prefixed=0, prefix_pending=0.
- in_ready=1 out of reset.
- Latency: a request accepted at edge N is visible on out_* after edge N, i.e. 1 cycle. Prefixes add one accepted request but no output.
- Throughput is one result per cycle while out_ready=1.
- Simultaneous out_ready=1 with a new accept: the output is replaced in the same edge; out_valid stays 1 with no bubble.
- Stall (out_valid=1, out_ready=0): in_ready=0; out_imm, out_prefixed and the state are frozen. A pending prefix is held indefinitely.
- Reset mid-stall or mid-prefix returns everything to the reset values immediately, without waiting for the clock.

## Test plan
- Defaults, IDLE, no stall:
  - imm_in=8'h80, imm_place=1 → out_imm=16'h0080 one cycle later.
  - imm_in=8'h1C, imm_place=0, ext_op=1 → 16'hFFFC.
  - imm_in=8'h1C, imm_place=0, ext_op=0 → 16'h001C.
  - imm_in=8'hFF, imm_place=0, ext_op=0 → 16'h001F.
- Prefix flow:
  - Prefix imm_in=8'hAB → prefix_pending=1, out_valid stays 0.
  - Then imm_in=8'hCD, imm_place=1 → out_imm=16'hABCD, out_prefixed=1, prefix_pending=0.
  - Prefix 8'h03, then imm_in=8'h1F, imm_place=0, ext_op=1 → out_imm=16'h007F, no sign extension.
- Back-to-back prefixes: prefix 8'h11, then prefix 8'h22, then imm_in=8'h33, imm_place=1 → out_imm=16'h2233.
- Backpressure:
  - Result 16'h0080 held with out_ready=0 for 3 cycles → in_ready=0 and out_imm stable throughout.
  - Raise out_ready with in_valid=1 and imm_in=8'h01, imm_place=1 → next out_imm=16'h0001 with out_valid continuously 1.
- Flush: prefix 8'h55 pending, an output valid, and flush=1 with a request present → next cycle out_valid=0, prefix_pending=0, request dropped. A following imm_in=8'h10, imm_place=1 → 16'h0010 with out_prefixed=0.
- Asynchronous reset asserted mid-cycle while stalled with a prefix pending → all outputs zero before the next clock edge, and in_ready=1.
